// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Issues word-aligned requests to the
//               instruction memory, presents fetched words to the IF/ID
//               register with valid/stall flow control, and buffers one word
//               in a skid entry when decode stalls. Branch redirects
//               override every other event; a redirect that arrives while a
//               request is outstanding drains that request first.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_pc_plus4,
  output logic [DATA_W-1:0] if_instr
);

  localparam logic [DATA_W-1:0] ALIGN_MASK = ~(DATA_W'(3));
  localparam logic [DATA_W-1:0] WORD_BYTES = DATA_W'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    BLOCK = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] pc;          // next address to request
  logic [DATA_W-1:0] drain_addr;  // address of the request being drained
  logic              skid_valid;
  logic [DATA_W-1:0] skid_pc;
  logic [DATA_W-1:0] skid_instr;

  logic              fetch_done;  // a live (non-discarded) fetch completes
  logic              consume;     // decode takes the output slot this edge
  logic              to_out;      // completing fetch goes straight to outputs
  logic              to_skid;     // completing fetch parks in the skid entry
  logic [DATA_W-1:0] pc_inc;

  assign fetch_done = (state == REQ) && imem_ack && !branch_taken;
  assign consume    = if_valid && !stall;
  assign to_out     = fetch_done && (!if_valid || !stall);
  assign to_skid    = fetch_done && if_valid && stall;
  assign pc_inc     = pc + WORD_BYTES;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and memory-request outputs
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    imem_addr  = pc & ALIGN_MASK;
    case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (branch_taken)  state_next = imem_ack ? REQ : DRAIN;
        else if (to_skid)  state_next = BLOCK;
      end
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr & ALIGN_MASK;
        // the drained data is always thrown away; only the target matters
        if (!branch_taken && imem_ack) state_next = REQ;
      end
      BLOCK: begin
        if (branch_taken || consume) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fetch address, output slot and skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      drain_addr  <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      if_instr    <= '0;
      skid_valid  <= 1'b0;
      skid_pc     <= '0;
      skid_instr  <= '0;
    end else if (branch_taken) begin
      pc         <= branch_target & ALIGN_MASK;
      if_valid   <= 1'b0;
      skid_valid <= 1'b0;
      // remember the in-flight address so it stays on the bus until acked
      if (state == REQ && !imem_ack) drain_addr <= pc;
    end else begin
      if (fetch_done) pc <= pc_inc;

      if (consume && skid_valid) begin
        if_pc       <= skid_pc;
        if_pc_plus4 <= skid_pc + WORD_BYTES;
        if_instr    <= skid_instr;
        if (fetch_done) begin
          skid_pc    <= pc;
          skid_instr <= imem_rdata;
        end else begin
          skid_valid <= 1'b0;
        end
      end else if (to_out) begin
        if_valid    <= 1'b1;
        if_pc       <= pc;
        if_pc_plus4 <= pc_inc;
        if_instr    <= imem_rdata;
      end else if (consume) begin
        if_valid <= 1'b0;
      end

      if (to_skid) begin
        skid_valid <= 1'b1;
        skid_pc    <= pc;
        skid_instr <= imem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. A second
//               instance with RESET_PC at the top of the address space
//               streams continuously to exercise address wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc, if_pc_plus4, if_instr;

  logic        req2;
  logic [31:0] addr2, rdata2;
  logic        valid2;
  logic [31:0] pc2, pc4_2, instr2;

  int tests = 0;
  int failed = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a << 8) ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_rdata = mem_f(imem_addr);
  assign rdata2     = mem_f(addr2);

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .if_instr(if_instr)
  );

  fetch_unit #(.DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(1'b1), .imem_rdata(rdata2),
    .branch_taken(1'b0), .branch_target(32'h0),
    .stall(1'b0),
    .if_valid(valid2), .if_pc(pc2), .if_pc_plus4(pc4_2),
    .if_instr(instr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests++; if (if_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin failed++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    tests++; if ({if_pc, if_pc_plus4, if_instr} !== 96'h0) begin failed++; $display("FAIL reset_outs: got %h/%h/%h expected zeros", if_pc, if_pc_plus4, if_instr); end
  endtask

  task automatic test_stream();
    imem_ack = 1'b1;
    stall = 1'b0;
    rst_n = 1'b1;
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin failed++; $display("FAIL stream_first_req: got req=%b addr=%h valid=%b expected 1/0/0", imem_req, imem_addr, if_valid); end
    for (int k = 0; k < 6; k++) begin
      tick();
      tests++; if (if_valid !== 1'b1 || if_pc !== 32'(4*k)) begin failed++; $display("FAIL stream_pc: got valid=%b pc=%h expected 1/%h", if_valid, if_pc, 32'(4*k)); end
      tests++; if (if_pc_plus4 !== 32'(4*k+4) || if_instr !== mem_f(32'(4*k))) begin failed++; $display("FAIL stream_data: got %h/%h expected %h/%h", if_pc_plus4, if_instr, 32'(4*k+4), mem_f(32'(4*k))); end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_wait_states();
    logic [31:0] a;
    for (int r = 0; r < 3; r++) begin
      a = 32'(24 + 4*r);
      for (int w = 0; w < 3; w++) begin
        tick();
        tests++; if (imem_req !== 1'b1 || imem_addr !== a || if_valid !== 1'b0) begin failed++; $display("FAIL wait_hold: got req=%b addr=%h valid=%b expected 1/%h/0", imem_req, imem_addr, if_valid, a); end
      end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      tests++; if (if_valid !== 1'b1 || if_pc !== a || if_instr !== mem_f(a)) begin failed++; $display("FAIL wait_data: got valid=%b pc=%h instr=%h expected 1/%h/%h", if_valid, if_pc, if_instr, a, mem_f(a)); end
    end
  endtask

  task automatic test_stall_skid();
    imem_ack = 1'b1;
    tick();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'd36) begin failed++; $display("FAIL skid_pre: got valid=%b pc=%h expected 1/24", if_valid, if_pc); end
    stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      tick();
      tests++; if (if_valid !== 1'b1 || if_pc !== 32'd36 || if_instr !== mem_f(32'd36) || imem_req !== 1'b0) begin failed++; $display("FAIL skid_frozen: got valid=%b pc=%h req=%b expected 1/24/0", if_valid, if_pc, imem_req); end
    end
    stall = 1'b0;
    tick();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'd40 || if_instr !== mem_f(32'd40)) begin failed++; $display("FAIL skid_drain: got valid=%b pc=%h expected 1/28", if_valid, if_pc); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd44) begin failed++; $display("FAIL skid_resume: got req=%b addr=%h expected 1/2c", imem_req, imem_addr); end
    tick();
    imem_ack = 1'b0;
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'd44 || if_pc_plus4 !== 32'd48) begin failed++; $display("FAIL skid_next: got valid=%b pc=%h expected 1/2c", if_valid, if_pc); end
  endtask

  task automatic test_reset_mid_req();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd48) begin failed++; $display("FAIL midrst_pre: got req=%b addr=%h expected 1/30", imem_req, imem_addr); end
    imem_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin failed++; $display("FAIL midrst_async: got req=%b addr=%h valid=%b pc=%h expected 0/0/0/0", imem_req, imem_addr, if_valid, if_pc); end
    tick();
    tick();
    tests++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || if_instr !== 32'h0) begin failed++; $display("FAIL midrst_ack_ignored: got valid=%b req=%b instr=%h expected 0/0/0", if_valid, imem_req, if_instr); end
    imem_ack = 1'b0;
  endtask

  task automatic test_branch_drain();
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    tests++; if (if_pc !== 32'd12 || imem_addr !== 32'h10) begin failed++; $display("FAIL drain_pre: got pc=%h addr=%h expected c/10", if_pc, imem_addr); end
    imem_ack = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h100;
    for (int w = 0; w < 3; w++) begin
      tick();
      branch_taken = 1'b0;
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_valid !== 1'b0) begin failed++; $display("FAIL drain_hold: got req=%b addr=%h valid=%b expected 1/10/0", imem_req, imem_addr, if_valid); end
    end
    imem_ack = 1'b1;
    tick();
    tests++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin failed++; $display("FAIL drain_discard: got valid=%b req=%b addr=%h expected 0/1/100", if_valid, imem_req, imem_addr); end
    tick();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== mem_f(32'h100)) begin failed++; $display("FAIL drain_target: got valid=%b pc=%h instr=%h expected 1/100/%h", if_valid, if_pc, if_instr, mem_f(32'h100)); end
  endtask

  task automatic test_branch_ack();
    branch_taken = 1'b1;
    branch_target = 32'h203;
    tick();
    branch_taken = 1'b0;
    tests++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin failed++; $display("FAIL bra_ack_redirect: got valid=%b req=%b addr=%h expected 0/1/200", if_valid, imem_req, imem_addr); end
    tick();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_pc_plus4 !== 32'h204) begin failed++; $display("FAIL bra_ack_target: got valid=%b pc=%h pc4=%h expected 1/200/204", if_valid, if_pc, if_pc_plus4); end
  endtask

  task automatic test_branch_skid();
    stall = 1'b1;
    tick();
    tests++; if (imem_req !== 1'b0 || if_pc !== 32'h200 || if_valid !== 1'b1) begin failed++; $display("FAIL bra_skid_block: got req=%b pc=%h valid=%b expected 0/200/1", imem_req, if_pc, if_valid); end
    branch_taken = 1'b1;
    branch_target = 32'h300;
    tick();
    branch_taken = 1'b0;
    stall = 1'b0;
    tests++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin failed++; $display("FAIL bra_skid_flush: got valid=%b req=%b addr=%h expected 0/1/300", if_valid, imem_req, imem_addr); end
    tick();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h300 || if_instr !== mem_f(32'h300)) begin failed++; $display("FAIL bra_skid_target: got valid=%b pc=%h expected 1/300", if_valid, if_pc); end
    tick();
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h304) begin failed++; $display("FAIL bra_skid_next: got valid=%b pc=%h expected 1/304", if_valid, if_pc); end
    imem_ack = 1'b0;
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    #1;
    tests++; if (addr2 !== 32'hFFFF_FFFC || req2 !== 1'b0 || valid2 !== 1'b0 || pc2 !== 32'h0 || pc4_2 !== 32'h0) begin failed++; $display("FAIL wrap_reset: got addr=%h req=%b valid=%b pc=%h expected fffffffc/0/0/0", addr2, req2, valid2, pc2); end
    tick();
    rst_n = 1'b1;
    tick();
    tests++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wrap_first_req: got req=%b addr=%h expected 1/fffffffc", req2, addr2); end
    tick();
    tests++; if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || pc4_2 !== 32'h0 || addr2 !== 32'h0) begin failed++; $display("FAIL wrap_first: got valid=%b pc=%h pc4=%h addr=%h expected 1/fffffffc/0/0", valid2, pc2, pc4_2, addr2); end
    tick();
    tests++; if (valid2 !== 1'b1 || pc2 !== 32'h0 || pc4_2 !== 32'h4 || instr2 !== mem_f(32'h0)) begin failed++; $display("FAIL wrap_second: got valid=%b pc=%h pc4=%h expected 1/0/4", valid2, pc2, pc4_2); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait_states();
    test_stall_skid();
    test_reset_mid_req();
    test_branch_drain();
    test_branch_ack();
    test_branch_skid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
